stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Single-clock, register-based FIFO with valid/ready streaming handshake on both sides.
//  Adds an optional registered output stage, runtime-programmable almost-full/almost-empty thresholds,
//  a live fill level, a high-watermark statistic and a synchronous flush.
//  Used between pipeline stages that need decoupling or backpressure.
// PARAMETERS
//  DATA_W   8  payload width in bits (>=1)
//  DEPTH    8  storage-array entries (>=2, any value; power of 2 not required)
//  REG_OUT  1  1 = registered output stage (capacity CAP = DEPTH+1); 0 = combinational read mux (CAP = DEPTH)
//  CW       fifo_pkg::fifo_cw(DEPTH+REG_OUT)  count width = $clog2(CAP+1)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rstn         in   1       asynchronous active-low reset
//  i_flush      in   1       synchronous flush, 1-cycle pulse
//  i_in_valid   in   1       upstream data valid
//  i_in_data    in   DATA_W  upstream data
//  o_in_ready   out  1       FIFO can accept (push = valid & ready)
//  o_out_valid  out  1       head word available
//  o_out_data   out  DATA_W  head word
//  i_out_ready  in   1       downstream accepts (pop = valid & ready)
//  i_afull_th   in   CW      almost-full threshold
//  i_aempty_th  in   CW      almost-empty threshold
//  o_alm_full   out  1       count >= i_afull_th
//  o_alm_empty  out  1       count <= i_aempty_th
//  o_count      out  CW      words held (array + output stage)
//  o_max_count  out  CW      high watermark of o_count since reset/flush/i_clr_stats
//  i_clr_stats  in   1       clears o_max_count to current o_count
// BEHAVIOUR
//  Reset (rstn low, async): pointers, count, max_count = 0; o_out_valid = 0; o_out_data = 0.
//   Register ready_q = 0, so o_in_ready = 0 while in reset and for the release edge.
//   ready_q = 1 at the first posedge after release. Array contents are not reset.
//  o_in_ready = ready_q & (count != CAP). Registered sources only; no combinational path from i_out_ready.
//  o_out_valid = (count != 0). Driven from a register when REG_OUT = 1.
//  Latency: a word pushed at edge N is visible on o_out_data/o_out_valid after edge N (1 cycle), for both REG_OUT values.
//   REG_OUT = 1 bypass: the word loads the output register directly if the array is empty
//   and the output register is empty or popped in the same cycle.
//   Otherwise it is written to the array at wrptr.
//  REG_OUT = 1 refill: when the output register is empty or popped and the array is non-empty,
//   it loads mem[rdptr] and rdptr advances.
//  Pointers wrap DEPTH-1 -> 0 by compare, not modulo-2^n.
//  Push & pop in the same cycle: count unchanged, order preserved.
//   At count = CAP no push is accepted (o_in_ready = 0); a pop still proceeds.
//   At count = 0 no pop occurs.
//  Push with o_in_ready = 0 is ignored: no state change, no error.
//   Holding i_in_data stable while o_in_ready = 0 is the upstream's duty.
//  Count arithmetic: count_nxt = count + push - pop, exact in CW bits.
//   Never exceeds CAP and never underflows.
//  Thresholds are sampled combinationally against the registered count.
//   Flags update in the cycle after the push/pop edge.
//   i_afull_th = 0 forces o_alm_full = 1. i_aempty_th >= CAP forces o_alm_empty = 1.
//  max_count <= max(max_count, count_nxt) every cycle.
//   i_clr_stats: max_count <= count_nxt.
//  i_flush (highest priority after reset): next cycle count = 0, pointers = 0, o_out_valid = 0, max_count = 0.
//   A push or pop coincident with flush is discarded.
//   o_in_ready is unaffected by flush (count != CAP after flush).
//  Reset mid-transfer: all in-flight data is lost; out_valid drops immediately (asynchronous).
// STRUCTURE
//  fifo_pkg: function fifo_cw(int cap) = $clog2(cap+1); typedef fifo_stats_t {max_count}.
//  Sub-module stream_fifo_outreg: output register with bypass/refill select (REG_OUT = 1 only).
//   Generated out when REG_OUT = 0.
//  Top: pointer/count/threshold/statistics logic plus storage array.
// TESTING
//  1. Reset: rstn low mid-stream -> o_out_valid = 0, o_count = 0, o_in_ready = 0.
//     Release -> o_in_ready = 1 one edge later.
//  2. DEPTH = 8, REG_OUT = 1, i_out_ready = 0: push 0x01..0x09 -> o_count = 9, o_in_ready = 0.
//     A 10th push (0x0A) is ignored. Drain -> 0x01..0x09 in order.
//  3. Count = CAP-1 with push & pop together -> count unchanged.
//     Count = CAP with valid & pop -> count = CAP-1, push not taken.
//  4. DEPTH = 5, REG_OUT = 0/1: 50 words with random in_valid/out_ready -> scoreboard match.
//     Pointer wraps 4 -> 0; o_count matches a model every cycle.
//  5. Thresholds: afull_th = 6, aempty_th = 1. Push 6 -> o_alm_full rises when o_count = 6.
//     Pop to 1 -> o_alm_empty = 1.
//  6. Fill to 7, pop 3, then i_flush with concurrent push.
//     o_max_count = 7 before the flush; after the flush o_count = 0, o_out_valid = 0, o_max_count = 0.
//     The pushed word never appears on the output.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and types for the stream FIFO: count-width function and statistics record.
package fifo_pkg;

    localparam int STATS_W = 16;

    function automatic int fifo_cw(input int cap);
        return $clog2(cap + 1);
    endfunction

    typedef struct packed {
        logic [STATS_W-1:0] max_count;
    } fifo_stats_t;

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready streaming bundle for both FIFO sides; slave is the FIFO, master is its environment.
interface stream_fifo_if #(
    parameter int DATA_W = 8
);
    logic              i_in_valid;
    logic [DATA_W-1:0] i_in_data;
    logic              o_in_ready;
    logic              o_out_valid;
    logic [DATA_W-1:0] o_out_data;
    logic              i_out_ready;

    modport slave (
        input  i_in_valid, i_in_data, i_out_ready,
        output o_in_ready, o_out_valid, o_out_data
    );

    modport master (
        output i_in_valid, i_in_data, i_out_ready,
        input  o_in_ready, o_out_valid, o_out_data
    );
endinterface

// File: rtl/stream_fifo_outreg.sv
// Registered head-of-queue stage: loads straight from the input when the array is empty,
// otherwise refills from the array head whenever it is empty or being popped.
module stream_fifo_outreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_arr_empty,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_arr_rd,
    output logic              o_arr_wr
);
    logic              slot_free;
    logic              bypass;
    logic              refill;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    assign slot_free = ~vld_p1 | i_pop;
    assign bypass    = i_push & i_arr_empty & slot_free;
    assign refill    = slot_free & ~i_arr_empty;
    assign o_arr_rd  = refill;
    assign o_arr_wr  = i_push & ~bypass;
    assign o_valid   = vld_p1;
    assign o_data    = data_p1;

    // output stage boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (i_flush) begin
            vld_p1  <= 1'b0;
        end else begin
            if (refill) begin
                data_p1 <= i_arr_data;
            end else if (bypass) begin
                data_p1 <= i_in_data;
            end
            vld_p1 <= refill | bypass | (vld_p1 & ~i_pop);
        end
    end
endmodule

// File: rtl/stream_fifo.sv
// Single-clock register FIFO with valid/ready on both sides, optional output register,
// programmable almost-full/empty flags, fill level, high watermark and synchronous flush.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int REG_OUT = 1,
    parameter int CW      = fifo_cw(DEPTH + REG_OUT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_flush,
    stream_fifo_if.slave  strm,
    input  logic [CW-1:0] i_afull_th,
    input  logic [CW-1:0] i_aempty_th,
    output logic          o_alm_full,
    output logic          o_alm_empty,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_max_count,
    input  logic          i_clr_stats
);
    localparam int CAP = DEPTH + REG_OUT;
    localparam int PW  = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrptr;
    logic [PW-1:0]     rdptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    fifo_stats_t       stats_q;
    fifo_stats_t       stats_nxt;
    logic              ready_q;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              push;
    logic              pop;
    logic              mem_wr;
    logic              mem_rd;

    // Wrap by compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = ready_q & (count != CW'(CAP));
    assign push     = strm.i_in_valid & in_ready;
    assign pop      = out_valid & strm.i_out_ready;

    assign strm.o_in_ready  = in_ready;
    assign strm.o_out_valid = out_valid;
    assign strm.o_out_data  = out_data;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic arr_empty;
            // The output register is always filled first, so the array holds count - out_valid words.
            assign arr_empty = (count == CW'(out_valid));

            stream_fifo_outreg #(
                .DATA_W (DATA_W)
            ) u_outreg (
                .clk         (clk),
                .rstn        (rstn),
                .i_flush     (i_flush),
                .i_push      (push),
                .i_pop       (pop),
                .i_arr_empty (arr_empty),
                .i_in_data   (strm.i_in_data),
                .i_arr_data  (mem[rdptr]),
                .o_valid     (out_valid),
                .o_data      (out_data),
                .o_arr_rd    (mem_rd),
                .o_arr_wr    (mem_wr)
            );
        end else begin : g_comb_out
            assign out_valid = (count != '0);
            assign out_data  = out_valid ? mem[rdptr] : '0;
            assign mem_rd    = pop;
            assign mem_wr    = push;
        end
    endgenerate

    always_comb begin
        count_nxt = count;
        stats_nxt = stats_q;
        if (i_flush) begin
            count_nxt           = '0;
            stats_nxt.max_count = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
            if (i_clr_stats || (STATS_W'(count_nxt) > stats_q.max_count)) begin
                stats_nxt.max_count = STATS_W'(count_nxt);
            end
        end
    end

    // storage stage boundary (data only, no reset)
    always_ff @(posedge clk) begin
        if (mem_wr && !i_flush) begin
            mem[wrptr] <= strm.i_in_data;
        end
    end

    // control stage boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrptr   <= '0;
            rdptr   <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            stats_q <= '0;
        end else begin
            ready_q <= 1'b1;
            count   <= count_nxt;
            stats_q <= stats_nxt;
            if (i_flush) begin
                wrptr <= '0;
                rdptr <= '0;
            end else begin
                if (mem_wr) wrptr <= ptr_inc(wrptr);
                if (mem_rd) rdptr <= ptr_inc(rdptr);
            end
        end
    end

    assign o_count     = count;
    assign o_max_count = stats_q.max_count[CW-1:0];
    assign o_alm_full  = (count >= i_afull_th);
    assign o_alm_empty = (count <= i_aempty_th);
endmodule
